// File: rtl/epd_defs.sv
// Shared definitions for the Ethernet packet field extractor.
//   - framing byte values and header field sizes
//   - parser FSM state encoding
//   - per-frame record layout and a helper that derives its error flags
package epd_defs;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam int         ADDR_BYTES    = 6;
    localparam int         TL_BYTES      = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_DST      = 3'd3,
        ST_SRC      = 3'd4,
        ST_TYPE     = 3'd5,
        ST_PAYLOAD  = 3'd6,
        ST_DISCARD  = 3'd7
    } epd_state_t;

    typedef struct packed {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] tl;
        logic [15:0] payload_len;
        logic        len_err;
        logic        tl_mismatch;
    } epd_rec_t;

    // Assemble a record from captured header fields and the payload count.
    function automatic epd_rec_t make_rec(input logic [47:0] dst,
                                          input logic [47:0] src,
                                          input logic [15:0] tl,
                                          input logic [15:0] len,
                                          input logic [15:0] min_len,
                                          input logic [15:0] max_len);
        epd_rec_t r;
        r.dst         = dst;
        r.src         = src;
        r.tl          = tl;
        r.payload_len = len;
        r.len_err     = (len < min_len) || (len > max_len);
        // A type/length value within the payload range is a length field.
        r.tl_mismatch = (tl <= max_len) && (len < tl);
        return r;
    endfunction

endpackage

// File: rtl/epd_rec_holder.sv
// One-deep record buffer with valid/ready output handshake.
//   clock, reset   : clock, synchronous active-high reset
//   load_req       : a completed frame record is offered this cycle
//   rec_in         : record offered with load_req
//   rec_ready      : consumer accepts when high with rec_valid
//   rec_valid, rec : held record and its valid flag
//   overflow       : one-cycle pulse when an offered record is dropped
module epd_rec_holder
    import epd_defs::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     load_req,
    input  epd_rec_t rec_in,
    input  logic     rec_ready,
    output logic     rec_valid,
    output epd_rec_t rec,
    output logic     overflow
);

    // A same-cycle handshake frees the slot for the incoming record.
    logic load;
    assign load = load_req && (!rec_valid || rec_ready);

    always_ff @(posedge clock) begin
        if (reset) begin
            rec_valid <= 1'b0;
            rec       <= '0;
            overflow  <= 1'b0;
        end else begin
            overflow <= load_req && !load;
            if (load) begin
                rec       <= rec_in;
                rec_valid <= 1'b1;
            end else if (rec_ready) begin
                rec_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/epd_field_extractor.sv
// Ethernet header field extractor. Parses preamble/SFD/DST/SRC/TYPE from the
// byte stream, counts payload bytes and emits one record per good frame.
//   clock, reset          : clock, synchronous active-high reset
//   data, control         : byte stream and frame-active qualifier
//   rec_valid, rec_ready  : record handshake
//   rec_dst_addr, rec_src_addr, rec_type_length, rec_payload_len,
//   rec_len_err, rec_tl_mismatch : record fields
//   overflow              : pulse when a finished frame is dropped
// Optional (EPD_EXT_STATS_EN): frame_count, drop_count saturating counters.
module epd_field_extractor
    import epd_defs::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_PAYLOAD  = 46,
    parameter int MAX_PAYLOAD  = 1500
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  data,
    input  logic        control,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [47:0] rec_dst_addr,
    output logic [47:0] rec_src_addr,
    output logic [15:0] rec_type_length,
    output logic [15:0] rec_payload_len,
    output logic        rec_len_err,
    output logic        rec_tl_mismatch,
    output logic        overflow
`ifdef EPD_EXT_STATS_EN
    ,
    output logic [7:0]  frame_count,
    output logic [7:0]  drop_count
`endif
);

    localparam logic [7:0] PRE_LAST  = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0] ADDR_LAST = 8'(ADDR_BYTES - 1);
    localparam logic [7:0] TL_LAST   = 8'(TL_BYTES - 1);

    epd_state_t  state;
    logic [7:0]  cnt;
    logic [47:0] dst, src;
    logic [15:0] tl, pay_cnt;
    logic        frame_done;
    epd_rec_t    rec_next, rec;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            dst     <= '0;
            src     <= '0;
            tl      <= '0;
            pay_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: if (control) begin
                    if (data == PREAMBLE_BYTE) begin
                        cnt   <= 8'd1;
                        state <= (PREAMBLE_LEN == 1) ? ST_SFD : ST_PREAMBLE;
                    end else begin
                        state <= ST_DISCARD;
                    end
                end
                ST_PREAMBLE: begin
                    if (!control)                   state <= ST_IDLE;
                    else if (data == PREAMBLE_BYTE) begin
                        cnt <= cnt + 8'd1;
                        if (cnt == PRE_LAST)        state <= ST_SFD;
                    end else                        state <= ST_DISCARD;
                end
                ST_SFD: begin
                    if (!control)                   state <= ST_IDLE;
                    else if (data == SFD_BYTE) begin
                        cnt   <= '0;
                        state <= ST_DST;
                    end else                        state <= ST_DISCARD;
                end
                ST_DST: begin
                    if (!control) state <= ST_IDLE;
                    else begin
                        dst <= {dst[39:0], data};
                        cnt <= cnt + 8'd1;
                        if (cnt == ADDR_LAST) begin
                            cnt   <= '0;
                            state <= ST_SRC;
                        end
                    end
                end
                ST_SRC: begin
                    if (!control) state <= ST_IDLE;
                    else begin
                        src <= {src[39:0], data};
                        cnt <= cnt + 8'd1;
                        if (cnt == ADDR_LAST) begin
                            cnt   <= '0;
                            state <= ST_TYPE;
                        end
                    end
                end
                ST_TYPE: begin
                    if (!control) state <= ST_IDLE;
                    else begin
                        tl  <= {tl[7:0], data};
                        cnt <= cnt + 8'd1;
                        if (cnt == TL_LAST) begin
                            cnt     <= '0;
                            pay_cnt <= '0;
                            state   <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (!control)                state <= ST_IDLE;
                    else if (pay_cnt != 16'hFFFF) pay_cnt <= pay_cnt + 16'd1;
                end
                ST_DISCARD: if (!control) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The captured fields are final in the cycle control drops in PAYLOAD.
    assign frame_done = (state == ST_PAYLOAD) && !control;
    assign rec_next   = make_rec(dst, src, tl, pay_cnt,
                                 16'(MIN_PAYLOAD), 16'(MAX_PAYLOAD));

    epd_rec_holder u_holder (
        .clock     (clock),
        .reset     (reset),
        .load_req  (frame_done),
        .rec_in    (rec_next),
        .rec_ready (rec_ready),
        .rec_valid (rec_valid),
        .rec       (rec),
        .overflow  (overflow)
    );

    assign rec_dst_addr    = rec.dst;
    assign rec_src_addr    = rec.src;
    assign rec_type_length = rec.tl;
    assign rec_payload_len = rec.payload_len;
    assign rec_len_err     = rec.len_err;
    assign rec_tl_mismatch = rec.tl_mismatch;

`ifdef EPD_EXT_STATS_EN
    // Drops are counted at frame end: discarded/runt frames from the parser,
    // overflow when a good frame finds the record slot still occupied.
    logic       fsm_drop, ovf_drop, rec_load;
    logic [1:0] drop_inc;
    logic [8:0] drop_sum;

    assign fsm_drop = !control && (state != ST_IDLE) && (state != ST_PAYLOAD);
    assign rec_load = frame_done && (!rec_valid || rec_ready);
    assign ovf_drop = frame_done && rec_valid && !rec_ready;
    assign drop_inc = {1'b0, fsm_drop} + {1'b0, ovf_drop};
    assign drop_sum = {1'b0, drop_count} + {7'd0, drop_inc};

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            if (rec_load && frame_count != 8'hFF) frame_count <= frame_count + 8'd1;
            drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end
`endif

endmodule
